// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I load/store engine.
// Holds the load/store opcode constants, the funct3 size encodings, the
// controller state type, and the access legality check used at issue time.
package mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  // True when funct3 is defined for this access type and the byte offset
  // is naturally aligned for the access size.
  function automatic logic access_ok(input logic       is_load,
                                     input logic [2:0] f3,
                                     input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      F3_BU:   ok = is_load;
      F3_HU:   ok = is_load & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering between a 32-bit word bus and RV32I sub-word accesses.
// Ports:
//   funct3     - access size/sign encoding
//   offset     - byte offset within the word (addr[1:0])
//   store_data - rs2 value to be written
//   rdata      - word returned by the bus
//   sel        - byte enables for the access
//   wdata      - store data replicated across all lanes of its size
//   load_data  - selected lane, sign- or zero-extended to 32 bits
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    sel       = '0;
    wdata     = '0;
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;

    // funct3[1:0] carries the size for both signed and unsigned forms
    case (funct3[1:0])
      2'b00: begin
        sel   = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel   = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        sel   = 4'b1111;
        wdata = store_data;
      end
    endcase

    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_handler.sv
// Load/store engine between the RV32I execute stage and the data bus.
// Runs one bus transaction per memory instruction and returns aligned,
// extended load data with a one-cycle register-file write strobe.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   valid, opcode, funct3    - instruction from execute stage
//   read_address             - load effective address
//   write_address            - store effective address
//   store_data, rd           - rs2 value, load destination register
//   bus_addr/wdata/sel       - word address, lane data, byte enables
//   bus_read/bus_write       - one-cycle request strobes
//   bus_rdata, bus_busy      - slave response
//   freeze                   - stall fetch while a transaction is pending
//   load_data/rd/we          - register-file writeback
//   access_fault             - pulse: misaligned or illegal funct3
//   bus_timeout              - pulse: slave busy for WAIT_LIMIT cycles
module data_mem_handler
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic        freeze,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        load_we,
  output logic        access_fault,
  output logic        bus_timeout
);

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  mem_state_t  state, state_next;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  wait_cnt;

  logic        in_load;
  logic        mem_op;
  logic [31:0] in_addr;
  logic        legal;
  logic        accept;
  logic        timeout_hit;

  logic [2:0]  f3_a;
  logic [1:0]  off_a;
  logic [3:0]  sel_a;
  logic [31:0] wdata_a;
  logic [31:0] load_a;

  assign in_load = (opcode == OPC_LOAD);
  assign mem_op  = valid && (in_load || opcode == OPC_STORE);
  assign in_addr = in_load ? read_address : write_address;
  assign legal   = access_ok(in_load, funct3, in_addr[1:0]);
  assign accept  = (state == IDLE) && mem_op && legal;

  // One aligner serves both directions: in IDLE it shapes the incoming
  // store, afterwards it extracts from the bus word using latched fields.
  assign f3_a  = (state == IDLE) ? funct3 : f3_q;
  assign off_a = (state == IDLE) ? in_addr[1:0] : off_q;

  byte_lane_align u_align (
    .funct3     (f3_a),
    .offset     (off_a),
    .store_data (store_data),
    .rdata      (bus_rdata),
    .sel        (sel_a),
    .wdata      (wdata_a),
    .load_data  (load_a)
  );

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: begin
        // completion is checked first so it wins on the limit cycle
        if (!bus_busy) begin
          state_next = DONE;
        end else if (wait_cnt == LIMIT_M1) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    freeze    = (state == REQ) || (state == WAIT) || accept;
    bus_read  = (state == REQ) && is_load_q;
    bus_write = (state == REQ) && !is_load_q;
    load_we   = (state == DONE) && is_load_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      is_load_q    <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_sel      <= '0;
      load_data    <= '0;
      load_rd      <= '0;
      access_fault <= 1'b0;
      bus_timeout  <= 1'b0;
    end else begin
      state        <= state_next;
      access_fault <= (state == IDLE) && mem_op && !legal;
      bus_timeout  <= timeout_hit;

      if (state == WAIT && bus_busy && !timeout_hit)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;

      if (accept) begin
        is_load_q <= in_load;
        f3_q      <= funct3;
        off_q     <= in_addr[1:0];
        bus_addr  <= {in_addr[31:2], 2'b00};
        bus_sel   <= sel_a;
        bus_wdata <= in_load ? '0 : wdata_a;
        if (in_load) load_rd <= rd;
      end

      if (state == WAIT && !bus_busy && is_load_q)
        load_data <= load_a;
    end
  end

endmodule

// File: tb/tb_data_mem_handler.sv
// Self-checking bench for data_mem_handler: directed vector table,
// hand-written reset/timeout sequences, and randomized transactions
// checked against an arithmetic reference model.
module tb_data_mem_handler;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, store_data;
  logic [4:0]  rd;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
  logic [3:0]  bus_sel;
  logic        bus_read, bus_write, bus_busy, freeze;
  logic [4:0]  load_rd;
  logic        load_we, access_fault, bus_timeout;

  always #5 clk = ~clk;

  data_mem_handler #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct3(funct3),
    .read_address(read_address), .write_address(write_address),
    .store_data(store_data), .rd(rd), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_read(bus_read),
    .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .freeze(freeze), .load_data(load_data), .load_rd(load_rd),
    .load_we(load_we), .access_fault(access_fault), .bus_timeout(bus_timeout)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int unsigned busy_n;
    logic        x_fault;
    logic        x_timeout;
    logic [3:0]  x_sel;
    logic [31:0] x_wdata;
    logic [31:0] x_ldata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid         = 1'b0;
    opcode        = 7'($urandom);
    funct3        = 3'($urandom);
    read_address  = $urandom;
    write_address = $urandom;
    store_data    = $urandom;
    rd            = 5'($urandom);
    bus_busy      = 1'b0;
    bus_rdata     = $urandom;
  endtask

  // A new legal load presented while busy must be ignored.
  task automatic distract();
    valid         = 1'b1;
    opcode        = 7'b0000011;
    funct3        = 3'b010;
    read_address  = $urandom & 32'hFFFF_FFFC;
    write_address = $urandom;
    store_data    = $urandom;
    rd            = 5'($urandom);
  endtask

  task automatic model(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rdata,
                       input int unsigned busy_n, output vec_t v);
    int unsigned size, o;
    logic        f3_ok;
    logic [31:0] word;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    f3_ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    o     = addr % 4;
    word  = rdata >> (8 * o);
    v.ld = ld; v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata; v.busy_n = busy_n;
    v.x_fault   = !f3_ok || (addr % size != 0);
    v.x_timeout = (busy_n >= LIMIT);
    v.x_sel     = 4'(((1 << size) - 1) << o);
    v.x_wdata   = (size == 1) ? 32'(data[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(data[15:0]) * 32'h0001_0001 : data;
    case (f3)
      3'd0:    v.x_ldata = 32'($signed(word[7:0]));
      3'd1:    v.x_ldata = 32'($signed(word[15:0]));
      3'd4:    v.x_ldata = 32'(word[7:0]);
      3'd5:    v.x_ldata = 32'(word[15:0]);
      default: v.x_ldata = word;
    endcase
  endtask

  task automatic run_txn(input vec_t v);
    logic [4:0]  r;
    logic [31:0] exp_addr;
    int unsigned n;
    r        = 5'($urandom);
    exp_addr = v.addr & 32'hFFFF_FFFC;
    next_cycle();
    valid         = 1'b1;
    opcode        = v.ld ? 7'b0000011 : 7'b0100011;
    funct3        = v.f3;
    read_address  = v.ld ? v.addr : $urandom;
    write_address = v.ld ? $urandom : v.addr;
    store_data    = v.data;
    rd            = r;
    bus_busy      = 1'b0;
    #1;
    chk("freeze_issue", 32'(freeze), 32'(!v.x_fault));
    chk("strobe_issue", 32'({bus_read, bus_write}), 32'(0));

    if (v.x_fault) begin
      next_cycle(); drive_idle(); #1;
      chk("fault_pulse", 32'(access_fault), 32'(1));
      chk("fault_no_bus", 32'({bus_read, bus_write}), 32'(0));
      chk("fault_freeze", 32'(freeze), 32'(0));
      chk("fault_no_we", 32'(load_we), 32'(0));
      next_cycle(); #1;
      chk("fault_width", 32'(access_fault), 32'(0));
      chk("fault_still_no_bus", 32'({bus_read, bus_write}), 32'(0));
      return;
    end

    next_cycle(); distract(); #1;
    chk("req_read", 32'(bus_read), 32'(v.ld));
    chk("req_write", 32'(bus_write), 32'(!v.ld));
    chk("req_addr", bus_addr, exp_addr);
    chk("req_sel", 32'(bus_sel), 32'(v.x_sel));
    if (!v.ld) chk("req_wdata", bus_wdata, v.x_wdata);
    chk("req_freeze", 32'(freeze), 32'(1));

    n = (v.busy_n < LIMIT) ? v.busy_n : LIMIT;
    for (int unsigned k = 0; k < n; k++) begin
      next_cycle(); distract();
      bus_busy  = 1'b1;
      bus_rdata = $urandom;
      #1;
      chk("wait_freeze", 32'(freeze), 32'(1));
      chk("wait_no_strobe", 32'({bus_read, bus_write}), 32'(0));
      chk("wait_addr_held", bus_addr, exp_addr);
      chk("wait_sel_held", 32'(bus_sel), 32'(v.x_sel));
      if (!v.ld) chk("wait_wdata_held", bus_wdata, v.x_wdata);
    end

    if (v.x_timeout) begin
      next_cycle(); drive_idle(); #1;
      chk("timeout_pulse", 32'(bus_timeout), 32'(1));
      chk("timeout_no_we", 32'(load_we), 32'(0));
      chk("timeout_freeze", 32'(freeze), 32'(0));
      chk("timeout_no_fault", 32'(access_fault), 32'(0));
      next_cycle(); #1;
      chk("timeout_width", 32'(bus_timeout), 32'(0));
      chk("timeout_no_we2", 32'(load_we), 32'(0));
      return;
    end

    next_cycle(); distract();
    bus_busy  = 1'b0;
    bus_rdata = v.rdata;
    #1;
    chk("complete_freeze", 32'(freeze), 32'(1));
    chk("complete_no_we", 32'(load_we), 32'(0));

    next_cycle(); distract();
    bus_busy  = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    chk("done_we", 32'(load_we), 32'(v.ld));
    if (v.ld) begin
      chk("done_data", load_data, v.x_ldata);
      chk("done_rd", 32'(load_rd), 32'(r));
    end
    chk("done_freeze", 32'(freeze), 32'(0));
    chk("done_no_pulses", 32'({access_fault, bus_timeout}), 32'(0));
    chk("done_no_strobe", 32'({bus_read, bus_write}), 32'(0));

    next_cycle(); drive_idle(); #1;
    chk("we_width", 32'(load_we), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, bus_addr, 32'h0);
    chk({tag, "_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_sel"}, 32'(bus_sel), 32'h0);
    chk({tag, "_ldata"}, load_data, 32'h0);
    chk({tag, "_lrd"}, 32'(load_rd), 32'h0);
    chk({tag, "_flags"},
        32'({bus_read, bus_write, freeze, load_we, access_fault, bus_timeout}), 32'h0);
  endtask

  vec_t tbl[14];
  vec_t v;

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (3) next_cycle();
    check_all_zero("reset");
    rst = 1'b0;

    //          ld    f3      addr          data          rdata        busy fault tmo  sel      wdata         ldata
    tbl[0]  = '{1'b0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 1'b0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 3, 1'b0, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    tbl[3]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        0, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    tbl[4]  = '{1'b1, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 1'b0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
    tbl[6]  = '{1'b1, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 2, 1'b0, 1'b0, 4'b1100, 32'h0,        32'h0000_8001};
    tbl[7]  = '{1'b1, 3'b010, 32'h0000_0008, 32'h0,        32'h1234_5678, 0, 1'b0, 1'b0, 4'b1111, 32'h0,        32'h1234_5678};
    tbl[8]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[9]  = '{1'b0, 3'b001, 32'h0000_0013, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};
    tbl[12] = '{1'b1, 3'b010, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 4, 1'b0, 1'b1, 4'b1111, 32'h0,        32'h0};
    tbl[13] = '{1'b1, 3'b000, 32'h0000_0041, 32'h0,        32'h0000_9A00, 3, 1'b0, 1'b0, 4'b0010, 32'h0,        32'hFFFF_FF9A};

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset in WAIT with the slave stuck busy.
    next_cycle();
    valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010;
    read_address = 32'h0000_0080; rd = 5'd9; bus_busy = 1'b0;
    next_cycle(); drive_idle();
    next_cycle(); bus_busy = 1'b1;
    next_cycle(); bus_busy = 1'b1; rst = 1'b1;
    next_cycle(); rst = 1'b0; bus_busy = 1'b1; #1;
    check_all_zero("rst_mid");
    for (int i = 0; i < 6; i++) begin
      next_cycle(); #1;
      chk("rst_after_we", 32'(load_we), 32'(0));
      chk("rst_after_freeze", 32'(freeze), 32'(0));
    end
    bus_busy = 1'b0;

    for (int i = 0; i < 250; i++) begin
      logic [2:0] f3r;
      logic [31:0] ar;
      f3r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      ar  = $urandom;
      model(1'($urandom), f3r, ar, $urandom, $urandom, $urandom_range(0, LIMIT + 1), v);
      run_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
